// File: rtl/trashbin_mem_pkg.sv
// rtl/trashbin_mem_pkg.sv - shared state encoding and default sizing for the arbitrated memory controller
package trashbin_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2
  } state_e;

  localparam int DEF_NUM_PORTS      = 2;
  localparam int DEF_ADDR_WIDTH     = 32;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_RAM_ADDR_WIDTH = 14;
  localparam int DEF_READ_LATENCY   = 1;
  localparam int DEF_WAIT_STATES    = 0;

  // Wide enough for WAIT_STATES + READ_LATENCY up to 15 + 4.
  localparam int CNT_W = 5;

endpackage

// File: rtl/round_robin_arbiter.sv
// rtl/round_robin_arbiter.sv - round-robin grant starting one past the last granted port
module round_robin_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = 1
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     last_grant_i,
  output logic [NUM_PORTS-1:0] grant_o,
  output logic [IDX_W-1:0]     grant_idx_o,
  output logic                 grant_valid_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    cand          = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    // Walk from the farthest offset down so the nearest requester wins last.
    for (int i = NUM_PORTS; i >= 1; i--) begin
      cand = IDX_W'((int'(last_grant_i) + i) % NUM_PORTS);
      if (req_i[cand]) begin
        grant_idx_o   = cand;
        grant_valid_o = 1'b1;
      end
    end
    grant_o = grant_valid_o ? (NUM_PORTS'(1) << grant_idx_o) : '0;
  end

endmodule

// File: rtl/arbitrated_memory_controller.sv
// rtl/arbitrated_memory_controller.sv - multi-port single-RAM controller with round-robin arbitration
module arbitrated_memory_controller
  import trashbin_mem_pkg::*;
#(
  parameter int NUM_PORTS      = DEF_NUM_PORTS,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int RAM_ADDR_WIDTH = DEF_RAM_ADDR_WIDTH,
  parameter int READ_LATENCY   = DEF_READ_LATENCY,
  parameter int WAIT_STATES    = DEF_WAIT_STATES
) (
  input  logic                                 CoreClock,
  input  logic                                 Reset,
  input  logic [NUM_PORTS-1:0]                 ReqValid,
  input  logic [NUM_PORTS-1:0]                 ReqWrite,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] ReqAddress,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] ReqWriteData,
  output logic [NUM_PORTS-1:0]                 ReqReady,
  output logic [NUM_PORTS-1:0]                 RespValid,
  output logic                                 RespError,
  output logic [DATA_WIDTH-1:0]                RespReadData,
  output logic [RAM_ADDR_WIDTH-1:0]            RamAddress,
  output logic [DATA_WIDTH-1:0]                RamWriteData,
  output logic                                 RamWriteEnable,
  input  logic [DATA_WIDTH-1:0]                RamReadData
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [CNT_W-1:0] ACCESS_LAST = CNT_W'(WAIT_STATES + READ_LATENCY - 1);

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          last_grant_q, last_grant_d;
  logic [IDX_W-1:0]          port_q, port_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      write_q, write_d;
  logic                      error_q, error_d;
  logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;

  logic [NUM_PORTS-1:0]      arb_grant;
  logic [IDX_W-1:0]          arb_idx;
  logic                      arb_valid;
  logic [ADDR_WIDTH-1:0]     sel_addr;
  logic                      in_range;

  round_robin_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_arb (
    .req_i         (ReqValid),
    .last_grant_i  (last_grant_q),
    .grant_o       (arb_grant),
    .grant_idx_o   (arb_idx),
    .grant_valid_o (arb_valid)
  );

  assign sel_addr = ReqAddress[arb_idx];
  assign in_range = (sel_addr[ADDR_WIDTH-1:RAM_ADDR_WIDTH] == '0);

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    port_d         = port_q;
    cnt_d          = cnt_q;
    write_d        = write_q;
    error_d        = error_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    ReqReady       = '0;
    RespValid      = '0;
    RespError      = 1'b0;
    RamWriteEnable = 1'b0;

    // Reset masks every strobe in the same cycle it is raised.
    if (!Reset) begin
      case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            ReqReady     = arb_grant;
            last_grant_d = arb_idx;
            port_d       = arb_idx;
            write_d      = ReqWrite[arb_idx];
            addr_d       = sel_addr[RAM_ADDR_WIDTH-1:0];
            wdata_d      = ReqWriteData[arb_idx];
            rdata_d      = '0;
            cnt_d        = ACCESS_LAST;
            error_d      = !in_range;
            state_d      = in_range ? ST_ACCESS : ST_RESPOND;
          end
        end
        ST_ACCESS: begin
          RamWriteEnable = write_q && (cnt_q == ACCESS_LAST);
          if (cnt_q == '0) begin
            if (!write_q) rdata_d = RamReadData;
            state_d = ST_RESPOND;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_RESPOND: begin
          RespValid = NUM_PORTS'(1) << port_q;
          RespError = error_q;
          state_d   = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CoreClock) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDX_W'(NUM_PORTS - 1);
      port_q       <= '0;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      error_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      error_q      <= error_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  assign RamAddress   = Reset ? '0 : addr_q;
  assign RamWriteData = wdata_q;
  assign RespReadData = rdata_q;

endmodule
